sram_bus_arbiter: RTL
=====================

# sram_bus_arbiter

Two-master to one-slave arbiter for the SRAM-like memory bus (req/wr/size/addr/wdata, addr_ok/data_ok/rdata). It shares the single external memory port between the instruction-fetch port and the data port driven by the mem stage. It tracks in-order outstanding transactions so each data_ok/rdata reaches the master that issued the request. It sits between the CPU core ports and the bus bridge at the top level.

## Interface
- MAX_OUTSTANDING, 2, depth of the owner FIFO; this is the maximum number of accepted requests still waiting for data_ok (1..4).
- clk  in  1  single clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req / inst_wr / inst_size / inst_addr / inst_wdata  in  1/1/2/32/32  instruction master request.
- inst_addr_ok / inst_data_ok  out  1/1  instruction master handshakes.
- inst_rdata  out  32  read data to the instruction master.
- data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/32/32  data master request; same encoding as the inst master (size 0=1B, 1=2B, 2=4B).
- data_addr_ok / data_data_ok  out  1/1  data master handshakes.
- data_rdata  out  32  read data to the data master.
- bus_req / bus_wr / bus_size / bus_addr / bus_wdata  out  1/1/2/32/32  slave request.
- bus_addr_ok / bus_data_ok  in  1/1  slave handshakes.
- bus_rdata  in  32  slave read data.
- busy  out  1  at least one transaction is outstanding.
- protocol_err  out  1  sticky flag: bus_data_ok arrived while nothing was outstanding.

## Operation
- Owner FIFO: MAX_OUTSTANDING entries, 1 bit each (0=inst, 1=data), with an occupancy count.
  - Push on a cycle where bus_req && bus_addr_ok; the pushed value is the current grant.
  - Pop on bus_data_ok when count>0.
  - Push and pop in the same cycle: the count is unchanged, the head advances, and the tail is written.
- Arbitration is combinational and re-evaluated each cycle, in this order:
  - If lock is set, grant = locked owner.
  - Else if data_req, grant = data; fixed priority, because the mem stage is stalled on it.
  - Else if inst_req, grant = inst.
  - Else there is no grant.
- Lock register:
  - Set when bus_req is asserted and bus_addr_ok is low; holds the current owner.
  - Cleared on the cycle bus_addr_ok is seen.
  - A master's request is therefore never switched away before it is accepted.
- FIFO full (count==MAX_OUTSTANDING):
  - bus_req=0 and both addr_ok outputs are 0.
  - Lock is still held if it was set.
  - A pop in the same cycle does NOT free a slot for that cycle, so there is no full-bypass path.
- Request path:
  - bus_req = granted master's req && !full.
  - bus_wr/size/addr/wdata come from the granted master, and are 0 when there is no grant.
- Addr_ok path: the granted master's addr_ok = bus_addr_ok && bus_req; the other master's addr_ok = 0.
- Response path:
  - data_ok is routed to the master at the FIFO head.
  - bus_rdata is broadcast to both rdata outputs.
- Response timing rule:
  - bus_data_ok is never expected in the same cycle as the addr_ok that accepted the transaction.
  - bus_data_ok with count==0 is dropped: no master data_ok, and protocol_err is set until reset.
- busy = (count != 0).

## Timing
- Reset (resetn low, asynchronous):
  - count=0, FIFO pointers=0, lock=0, protocol_err=0.
  - All outputs are 0 while resetn is low, including bus_req.
- Reset mid-transaction discards all outstanding ownership. After release, the first bus_data_ok sets protocol_err; the slave must be reset alongside.
- Request to bus_req: 0 cycles (combinational). addr_ok to master: 0 cycles.
- bus_data_ok to master data_ok: 0 cycles.
- Earliest next response: an accepted request can receive data_ok from the cycle after acceptance.
- Throughput: one accept per cycle while not full; back-to-back accepts from alternating masters are allowed.
- Pointer wrap-around is modulo MAX_OUTSTANDING. The count width is clog2(MAX_OUTSTANDING+1).

## Test plan
- Idle reset:
  - Stimulus: hold resetn=0 with inst_req=1.
  - Required: bus_req=0, busy=0, protocol_err=0.
  - Release reset: same cycle, bus_req=1 and bus_addr=inst_addr.
- Priority:
  - Stimulus: inst_req and data_req both 1 in cycle 0, bus_addr_ok=1; data_addr=0x00001000.
  - Required in cycle 0: bus_addr=0x00001000, data_addr_ok=1, inst_addr_ok=0.
  - Required in cycle 1: the inst request is accepted.
  - Stimulus: bus_data_ok pulses in cycles 3 and 4.
  - Required: data_data_ok in cycle 3, inst_data_ok in cycle 4.
- Lock:
  - Stimulus: inst_req=1 with bus_addr_ok=0 for 3 cycles; data_req rises in cycle 1.
  - Required: bus_addr stays at inst_addr through cycle 3 when addr_ok=1.
  - Required: the data request is granted in cycle 4.
- Full:
  - Stimulus: with MAX_OUTSTANDING=2, two accepts and no data_ok.
  - Required: bus_req=0 and busy=1.
  - Stimulus: data_ok plus a pending request in the same cycle.
  - Required: still no accept that cycle; accept on the next cycle.
- Wrap:
  - Stimulus: 10 alternating inst/data transactions, each with 2-cycle data latency.
  - Required: every data_ok reaches its issuer in order, and the FIFO count never exceeds 2.
- Protocol error:
  - Stimulus: bus_data_ok with count==0.
  - Required: no master data_ok; protocol_err=1 persists until resetn=0.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the SRAM-like bus.
// An owner FIFO routes each data_ok/rdata back to the master that issued the request.
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        protocol_err
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  logic [(1<<PW)-1:0] owner_q;
  logic [PW-1:0]      head_q;
  logic [PW-1:0]      tail_q;
  logic [CW-1:0]      count_q;
  logic               lock_q;
  owner_e             lock_owner_q;
  logic               perr_q;

  owner_e grant;
  logic   grant_vld;
  logic   full;
  logic   push;
  logic   pop;
  logic   head_owner;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A locked owner keeps the bus until its pending request is accepted.
  always_comb begin
    grant     = OWN_INST;
    grant_vld = 1'b0;
    if (lock_q) begin
      grant     = lock_owner_q;
      grant_vld = 1'b1;
    end else if (data_req) begin
      grant     = OWN_DATA;
      grant_vld = 1'b1;
    end else if (inst_req) begin
      grant     = OWN_INST;
      grant_vld = 1'b1;
    end
  end

  // Full is taken from the registered count only: a same-cycle pop never opens a slot.
  assign full = (count_q == CNT_MAX);

  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    if (resetn && grant_vld) begin
      if (grant == OWN_DATA) begin
        bus_req   = data_req && !full;
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_req   = inst_req && !full;
        bus_wr    = inst_wr;
        bus_size  = inst_size;
        bus_addr  = inst_addr;
        bus_wdata = inst_wdata;
      end
    end
  end

  assign push       = bus_req && bus_addr_ok;
  assign pop        = bus_data_ok && (count_q != '0);
  assign head_owner = owner_q[head_q];

  assign inst_addr_ok = push && (grant == OWN_INST);
  assign data_addr_ok = push && (grant == OWN_DATA);
  assign inst_data_ok = resetn && pop && !head_owner;
  assign data_data_ok = resetn && pop && head_owner;
  assign inst_rdata   = resetn ? bus_rdata : 32'd0;
  assign data_rdata   = resetn ? bus_rdata : 32'd0;
  assign busy         = (count_q != '0);
  assign protocol_err = perr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_INST;
      perr_q       <= 1'b0;
    end else begin
      if (push) begin
        owner_q[tail_q] <= (grant == OWN_DATA);
        tail_q          <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Lock follows every presented request; it clears only on acceptance.
      if (bus_req) begin
        lock_q       <= !bus_addr_ok;
        lock_owner_q <= grant;
      end
      if (bus_data_ok && (count_q == '0)) begin
        perr_q <= 1'b1;
      end
    end
  end

endmodule
